// File: rtl/lfsr_burst_if.sv
// Command and stream handshake bundle for lfsr_burst_ctrl.
// The slave side is the controller; the master side is the command source and data consumer.
interface lfsr_burst_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_seed;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             seed_err;

  modport master (
    output cmd_valid, cmd_seed, cmd_len, abort, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, busy, done, seed_err
  );

  modport slave (
    input  cmd_valid, cmd_seed, cmd_len, abort, out_ready,
    output cmd_ready, out_valid, out_data, out_last, busy, done, seed_err
  );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// Seeds a Fibonacci LFSR from an accepted command and streams exactly cmd_len words
// with valid/ready backpressure, flagging the final beat and pulsing done at the end.
module lfsr_burst_ctrl #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  lfsr_burst_if.slave bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done;
  logic             r_seed_err;

  logic [WIDTH-1:0] w_tap_bits;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_seed;
  logic             w_idle;
  logic             w_run;
  logic             w_seed_zero;
  logic             w_cmd_fire;
  logic             w_beat_fire;
  logic             w_is_last;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_taps
      assign w_tap_bits[gi] = r_lfsr[gi] & TAPS[gi];
    end
  endgenerate

  assign w_lfsr_next = {r_lfsr[WIDTH-2:0], ^w_tap_bits};

  // An all-zero seed would lock the register up, so it is replaced by 1.
  assign w_seed_zero = (bus.cmd_seed == '0);
  assign w_seed      = w_seed_zero ? SEED_ONE : bus.cmd_seed;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_run       = (r_state == ST_RUN);
  assign w_cmd_fire  = bus.cmd_valid & w_idle;
  assign w_beat_fire = w_run & bus.out_ready;
  assign w_is_last   = (r_remaining == CNT_ONE);

  assign bus.cmd_ready = w_idle;
  assign bus.out_valid = w_run;
  assign bus.busy      = w_run;
  assign bus.out_data  = r_lfsr;
  assign bus.out_last  = w_is_last & w_run;
  assign bus.done      = r_done;
  assign bus.seed_err  = r_seed_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_seed_err  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_seed_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_seed_err <= w_seed_zero;
            if (bus.cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
              r_lfsr      <= w_seed;
              r_remaining <= bus.cmd_len;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a coincident beat; that beat is treated as not delivered.
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else if (w_beat_fire) begin
            r_lfsr      <= w_lfsr_next;
            r_remaining <= r_remaining - CNT_ONE;
            if (w_is_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Self-checking bench for lfsr_burst_ctrl: table of directed commands, hand-written
// reset/abort sequences, then random commands checked against a beat-level model.
module tb_lfsr_burst_ctrl;

  localparam int              WIDTH = 8;
  localparam int              CNT_W = 8;
  localparam logic [WIDTH-1:0] TAPS = 8'hB8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_burst_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lfsr_burst_ctrl #(.WIDTH(WIDTH), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] seed;
    logic [7:0] len;
    int         stall;        // 0 always ready, 1 alternate ready, 2 random ready
    int         abort_after;  // abort once this many beats are delivered, -1 never
    int         exp_beats;
    logic [7:0] exp_last;
    logic       exp_seed_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next word of the sequence: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [7:0] model_step(input logic [7:0] v);
    int ones;
    ones = $countones(v & TAPS);
    return {v[6:0], 1'((ones % 2))};
  endfunction

  task automatic check_reset_state();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last",  bus.out_last,  0);
    check("rst_busy",      bus.busy,      0);
    check("rst_done",      bus.done,      0);
    check("rst_seed_err",  bus.seed_err,  0);
    check("rst_out_data",  bus.out_data,  0);
  endtask

  // Entered and left at a negedge; on return the cycle showing done (if any) is current.
  task automatic run_cmd(input logic [7:0] seed, input logic [7:0] len, input int stall,
                         input int abort_after, output int delivered,
                         output logic [7:0] last_word, output logic saw_seed_err);
    logic [7:0] expw;
    int         bound;
    logic       rdy;
    logic       ab;
    logic       finished;
    delivered = 0;
    last_word = 8'h00;
    finished  = 1'b0;
    check("cmd_ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_seed  = seed;
    bus.cmd_len   = len;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    saw_seed_err  = bus.seed_err;
    check("seed_err_t1", bus.seed_err, (seed == 8'h00));
    check("done_t1",     bus.done,     (len == 8'h00));
    if (len == 8'h00) begin
      check("zero_len_out_valid", bus.out_valid, 0);
      check("zero_len_cmd_ready", bus.cmd_ready, 1);
      check("zero_len_busy",      bus.busy,      0);
    end else begin
      expw  = (seed == 8'h00) ? 8'h01 : seed;
      bound = int'(len) * 4 + 40;
      for (int k = 0; k < bound && !finished; k++) begin
        if (k > 0) begin
          check("seed_err_single", bus.seed_err, 0);
          check("done_during_run", bus.done,     0);
        end
        check("out_valid_run", bus.out_valid, 1);
        check("busy_run",      bus.busy,      1);
        check("cmd_ready_run", bus.cmd_ready, 0);
        check("out_data",      bus.out_data,  expw);
        check("out_last",      bus.out_last,  (delivered == int'(len) - 1));
        case (stall)
          0:       rdy = 1'b1;
          1:       rdy = (k % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        ab = (abort_after >= 0) && (delivered == abort_after);
        bus.out_ready = rdy;
        bus.abort     = ab;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        if (ab) begin
          check("abort_out_valid", bus.out_valid, 0);
          check("abort_done",      bus.done,      1);
          check("abort_cmd_ready", bus.cmd_ready, 1);
          finished = 1'b1;
        end else if (rdy) begin
          last_word = expw;
          delivered++;
          expw = model_step(expw);
          if (delivered == int'(len)) begin
            check("end_out_valid", bus.out_valid, 0);
            check("end_out_last",  bus.out_last,  0);
            check("end_done",      bus.done,      1);
            check("end_cmd_ready", bus.cmd_ready, 1);
            finished = 1'b1;
          end
        end
      end
      if (!finished) check("burst_timeout", 1, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         got_beats;
    logic [7:0] got_last;
    logic       got_serr;
    int         ab;
    int         exp_beats;
    logic [7:0] rs;
    logic [7:0] rl;

    bus.cmd_valid = 1'b0;
    bus.cmd_seed  = 8'h00;
    bus.cmd_len   = 8'h00;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'h01, 8'd5,   0, -1, 5, 8'h11, 1'b0};
    vecs[1] = '{8'h01, 8'd5,   1, -1, 5, 8'h11, 1'b0};
    vecs[2] = '{8'h00, 8'd2,   0, -1, 2, 8'h02, 1'b1};
    vecs[3] = '{8'h55, 8'd0,   0, -1, 0, 8'h00, 1'b0};
    vecs[4] = '{8'h01, 8'd255, 0,  3, 3, 8'h04, 1'b0};
    vecs[5] = '{8'hFF, 8'd3,   2, -1, 3, 8'hFC, 1'b0};
    vecs[6] = '{8'h11, 8'd1,   1, -1, 1, 8'h11, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // Consecutive entries also exercise back-to-back commands in the done cycle.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].seed, vecs[i].len, vecs[i].stall, vecs[i].abort_after,
              got_beats, got_last, got_serr);
      $display("vec %0d: seed=0x%02h len=%0d beats=%0d last=0x%02h seed_err=%0d",
               i, vecs[i].seed, vecs[i].len, got_beats, got_last, got_serr);
      check("vec_beats",    got_beats, vecs[i].exp_beats);
      check("vec_seed_err", got_serr,  vecs[i].exp_seed_err);
      if (vecs[i].exp_beats > 0) check("vec_last_word", got_last, vecs[i].exp_last);
    end
    @(negedge clk);
    check("done_single_pulse", bus.done, 0);

    // Abort while idle has no effect.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_busy",      bus.busy,      0);
    check("idle_abort_done",      bus.done,      0);
    check("idle_abort_cmd_ready", bus.cmd_ready, 1);
    $display("idle abort: busy=%0d done=%0d", bus.busy, bus.done);

    // Reset in the middle of a long burst, then a single-beat command.
    bus.cmd_valid = 1'b1;
    bus.cmd_seed  = 8'h01;
    bus.cmd_len   = 8'd255;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    check_reset_state();
    @(negedge clk);
    check("post_rst_no_done", bus.done, 0);
    run_cmd(8'h11, 8'd1, 0, -1, got_beats, got_last, got_serr);
    $display("after reset: seed=0x11 len=1 beats=%0d last=0x%02h", got_beats, got_last);
    check("rst_then_beats", got_beats, 1);
    check("rst_then_last",  got_last,  8'h11);

    for (int i = 0; i < 25; i++) begin
      rs = 8'($urandom);
      if (i % 6 == 0) rs = 8'h00;
      rl = 8'($urandom_range(0, 10));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(rl))) : -1;
      exp_beats = (ab >= 0 && ab < int'(rl)) ? ab : int'(rl);
      run_cmd(rs, rl, 2, ab, got_beats, got_last, got_serr);
      $display("rand %0d: seed=0x%02h len=%0d abort_after=%0d beats=%0d",
               i, rs, rl, ab, got_beats);
      check("rand_beats",    got_beats, exp_beats);
      check("rand_seed_err", got_serr,  (rs == 8'h00));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rand_done_single", bus.done, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
